multi_word_adder_ctrl: RTL
==========================

# multi_word_adder_ctrl

Sequencing controller that performs multi-precision add/subtract of 16*WORDS-bit operands by time-multiplexing a single 16-bit CLA slice adder (ports s, c_out, a, b, c_in), one 16-bit word per clock, least-significant word first. The slice carry-out is registered and fed back as the next word's carry-in. The block sits between a requester issuing start/operand pulses and the combinational 16-bit adder it owns internally.

## Interface
- WORDS, default 4: number of 16-bit words per operand (2..8); operand width N = 16*WORDS.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  N  operand A; sampled with start.
- b  input  N  operand B; sampled with start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse in DONE.
- sum  output  N  result register.
- c_out  output  1  final carry (sub: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow of the N-bit result.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset (async, any state, including mid-RUN): state=IDLE, word index=0, carry reg=0, operand regs=0, sum=0, c_out=0, overflow=0, done=0, busy=0, ready=1.
- IDLE: on start=1 latch a_reg=a, b_reg = op_sub ? ~b : b, carry reg=op_sub, index=0, sum=0, c_out=0, overflow=0; go RUN. start=0: stay.
- RUN, each cycle: slice inputs a_reg[16*idx+:16], b_reg[16*idx+:16], c_in=carry reg; sum[16*idx+:16] <= slice s; carry reg <= slice c_out; idx <= idx+1. When idx==WORDS-1: c_out <= slice c_out, overflow <= slice c_out XOR (a_reg[N-1] ^ b_reg[N-1] ^ slice s[15]) (carry into MSB XOR carry out), idx <= 0, go DONE.
- DONE: done=1 for exactly one cycle, unconditionally go IDLE.
- start while busy or in DONE: ignored, no queuing; operands/op_sub changes after the accepted cycle have no effect.
- sum, c_out, overflow hold their values after DONE until the next accepted start (which clears them) or reset.
- Width rules: all slice arithmetic is 16-bit modulo; index counter ceil(log2(WORDS)) bits, never exceeds WORDS-1; subtraction is a + ~b + 1 via initial carry only.

## Timing
- Cycle 0: start sampled high in IDLE → ready falls, busy rises at cycle 1.
- RUN occupies cycles 1..WORDS; word k written at the end of cycle k+1.
- done high during cycle WORDS+1; sum/c_out/overflow valid from that cycle.
- ready high again at cycle WORDS+2; back-to-back start accepted at WORDS+2, so throughput is one operation per WORDS+2 cycles.
- Slice adder is purely combinational inside one RUN cycle; no combinational path from start/a/b to any output.
- Reset deasserted mid-cycle: the first active edge afterwards is in IDLE; no partial result survives.

## Test plan
- Reset: assert rst with garbage inputs → ready=1, busy=0, done=0, sum=0, c_out=0, overflow=0; rst pulsed mid-RUN → same values immediately, no done pulse follows.
- Add with full carry ripple (WORDS=4): a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, op_sub=0 → done in cycle 5, sum=0, c_out=1, overflow=0.
- Subtract with borrow: a=0x5, b=0x7, op_sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, overflow=0; a=0x7, b=0x5 → sum=0x2, c_out=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 add → sum=0x8000_0000_0000_0000, c_out=0, overflow=1; a=0x8000_0000_0000_0000 minus 0x1 → sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Handshake: start held high continuously with changing operands → operations accepted only at cycles 0, 6, 12; each result matches operands present at its accept cycle; done exactly one cycle each.
- WORDS=2: a=0x0001_FFFF, b=0x0000_0001 add → done in cycle 3, sum=0x0002_0000, c_out=0, overflow=0.

Source files
------------

// File: rtl/multi_word_adder_ctrl.sv
// Multi-precision add/subtract controller: one 16-bit lookahead slice is reused
// word by word (LSW first), with the slice carry registered between words.

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out
);
  logic [15:0] p, g, c;
  logic [4:0]  gc;
  logic [3:0]  gj, pj;

  // 4-bit lookahead groups; group carries chain from group to group
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    gc    = '0;
    gj    = '0;
    pj    = '0;
    gc[0] = c_in;
    for (int unsigned j = 0; j < 4; j++) begin
      gj = g[4*j +: 4];
      pj = p[4*j +: 4];
      c[4*j]   = gc[j];
      c[4*j+1] = gj[0] | (pj[0] & gc[j]);
      c[4*j+2] = gj[1] | (pj[1] & gj[0]) | (pj[1] & pj[0] & gc[j]);
      c[4*j+3] = gj[2] | (pj[2] & gj[1]) | (pj[2] & pj[1] & gj[0])
               | (pj[2] & pj[1] & pj[0] & gc[j]);
      gc[j+1]  = gj[3] | (pj[3] & gj[2]) | (pj[3] & pj[2] & gj[1])
               | (pj[3] & pj[2] & pj[1] & gj[0])
               | (pj[3] & pj[2] & pj[1] & pj[0] & gc[j]);
    end
    s     = p ^ c;
    c_out = gc[4];
  end
endmodule

module multi_word_adder_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                c_out,
  output logic                overflow
);
  localparam int unsigned N  = 16 * WORDS;
  localparam int unsigned IW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic          carry;
  logic [N-1:0]  a_reg, b_reg;
  logic [15:0]   a_word, b_word, s_word;
  logic          co_word;
  logic          last;

  assign a_word = a_reg[16*idx +: 16];
  assign b_word = b_reg[16*idx +: 16];
  assign last   = (idx == IW'(WORDS - 1));

  cla16 u_slice (
    .a     (a_word),
    .b     (b_word),
    .c_in  (carry),
    .s     (s_word),
    .c_out (co_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= op_sub ? ~b : b;
            carry    <= op_sub;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          sum[16*idx +: 16] <= s_word;
          carry             <= co_word;
          if (last) begin
            c_out <= co_word;
            // carry into the MSB recovered from the top bit's sum equation
            overflow <= co_word ^ (a_reg[N-1] ^ b_reg[N-1] ^ s_word[15]);
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
